// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - IF stage bundle: ID handshake, branch redirect and inst SRAM port.
// fs_adef and its modport entries exist only when IF_ADEF_CHECK_EN is defined.
interface if_stage_if;
  logic        ds_allowin;
  logic        br_taken;
  logic [31:0] br_target;
  logic        fs_to_ds_valid;
  logic [31:0] fs_pc;
  logic [31:0] fs_inst;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
`ifdef IF_ADEF_CHECK_EN
  logic        fs_adef;

  modport master (
    input  ds_allowin, br_taken, br_target, inst_sram_rdata,
    output fs_to_ds_valid, fs_pc, fs_inst, fs_adef,
           inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata
  );
  modport slave (
    output ds_allowin, br_taken, br_target, inst_sram_rdata,
    input  fs_to_ds_valid, fs_pc, fs_inst, fs_adef,
           inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata
  );
`else
  modport master (
    input  ds_allowin, br_taken, br_target, inst_sram_rdata,
    output fs_to_ds_valid, fs_pc, fs_inst,
           inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata
  );
  modport slave (
    output ds_allowin, br_taken, br_target, inst_sram_rdata,
    input  fs_to_ds_valid, fs_pc, fs_inst,
           inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata
  );
`endif
endinterface

// File: rtl/if_stage.sv
// rtl/if_stage.sv - LoongArch instruction-fetch stage: PC, next-PC mux, inst SRAM, redirect squash.
// Optional misaligned-fetch detection is enabled by defining IF_ADEF_CHECK_EN.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000,
  parameter logic [31:0] NOP_INST = 32'h02800000
) (
  input logic        clk,
  input logic        reset,
  if_stage_if.master bus
);

  logic        fs_valid_q, fs_valid_d;
  logic [31:0] fs_pc_q, fs_pc_d;
  logic        br_pending_q, br_pending_d;
  logic [31:0] br_target_r_q, br_target_r_d;
  logic        cancel_q, cancel_d;
  logic        rdata_fresh_q, rdata_fresh_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_q, buf_d;
`ifdef IF_ADEF_CHECK_EN
  logic        adef_q, adef_d;
  logic        misaligned;
`endif

  logic        to_fs_valid;
  logic        fs_allowin;
  logic        fetch_go;
  logic        fs_to_ds_valid;
  logic        consumed;
  logic [31:0] nextpc;
  logic [31:0] raw_inst;

  always_comb begin
    if (bus.br_taken)      nextpc = bus.br_target;
    else if (br_pending_q) nextpc = br_target_r_q;
    else                   nextpc = fs_pc_q + 32'd4;
  end

  // No branch stall source exists here, so allowin reduces to "empty or ID takes it".
  assign to_fs_valid    = ~reset;
  assign fs_allowin     = ~fs_valid_q | bus.ds_allowin;
  assign fetch_go       = to_fs_valid & fs_allowin;
  assign fs_to_ds_valid = fs_valid_q & ~bus.br_taken & ~br_pending_q & ~cancel_q;
  assign consumed       = bus.ds_allowin & fs_to_ds_valid;
  assign raw_inst       = buf_valid_q ? buf_q : bus.inst_sram_rdata;

`ifdef IF_ADEF_CHECK_EN
  assign misaligned       = |nextpc[1:0];
  assign bus.inst_sram_en = fetch_go & ~misaligned;
  assign bus.fs_adef      = adef_q;
  assign bus.fs_inst      = (fs_to_ds_valid & ~adef_q) ? raw_inst : NOP_INST;
`else
  assign bus.inst_sram_en = fetch_go;
  assign bus.fs_inst      = fs_to_ds_valid ? raw_inst : NOP_INST;
`endif

  assign bus.inst_sram_addr  = nextpc;
  assign bus.inst_sram_we    = 4'h0;
  assign bus.inst_sram_wdata = 32'h0;
  assign bus.fs_to_ds_valid  = fs_to_ds_valid;
  assign bus.fs_pc           = fs_pc_q;

  always_comb begin
    fs_valid_d    = fs_valid_q;
    fs_pc_d       = fs_pc_q;
    br_pending_d  = br_pending_q;
    br_target_r_d = br_target_r_q;
    cancel_d      = cancel_q;
    rdata_fresh_d = fetch_go;
    buf_valid_d   = buf_valid_q;
    buf_d         = buf_q;
`ifdef IF_ADEF_CHECK_EN
    adef_d        = adef_q;
`endif
    if (fetch_go) begin
      fs_valid_d   = 1'b1;
      fs_pc_d      = nextpc;
      buf_valid_d  = 1'b0;
      br_pending_d = 1'b0;
      cancel_d     = 1'b0;
`ifdef IF_ADEF_CHECK_EN
      adef_d       = misaligned;
`endif
    end else begin
      if (consumed) fs_valid_d = 1'b0;
      if (bus.br_taken) begin
        br_pending_d  = 1'b1;
        br_target_r_d = bus.br_target;
        cancel_d      = 1'b1;
      end
      // SRAM data is only valid the cycle after a read; hold it while ID is stalled.
      if (rdata_fresh_q && !buf_valid_q && !consumed) begin
        buf_valid_d = 1'b1;
        buf_d       = bus.inst_sram_rdata;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fs_valid_q    <= 1'b0;
      fs_pc_q       <= RESET_PC - 32'd4;
      br_pending_q  <= 1'b0;
      br_target_r_q <= 32'h0;
      cancel_q      <= 1'b0;
      rdata_fresh_q <= 1'b0;
      buf_valid_q   <= 1'b0;
      buf_q         <= 32'h0;
`ifdef IF_ADEF_CHECK_EN
      adef_q        <= 1'b0;
`endif
    end else begin
      fs_valid_q    <= fs_valid_d;
      fs_pc_q       <= fs_pc_d;
      br_pending_q  <= br_pending_d;
      br_target_r_q <= br_target_r_d;
      cancel_q      <= cancel_d;
      rdata_fresh_q <= rdata_fresh_d;
      buf_valid_q   <= buf_valid_d;
      buf_q         <= buf_d;
`ifdef IF_ADEF_CHECK_EN
      adef_q        <= adef_d;
`endif
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - Self-checking bench for if_stage: program-order model plus directed vectors.
// Defining IF_ADEF_CHECK_EN also exercises the misaligned-fetch path.
module tb_if_stage;
  localparam logic [31:0] RESET_PC = 32'h1c000000;
  localparam logic [31:0] NOP_INST = 32'h02800000;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [31:0] exp_next;

  if_stage_if bus ();

  if_stage #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-addressed memory image: upper half is the word address bits, lower half their inverse.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [15:0] lo;
    lo = {a[15:2], 2'b00};
    return {lo, ~lo};
  endfunction

  function automatic logic [31:0] exp_inst(input logic [31:0] pc);
`ifdef IF_ADEF_CHECK_EN
    if (pc[1:0] != 2'b00) return NOP_INST;
`endif
    return mem_word(pc);
  endfunction

  // Synchronous SRAM; output wanders with garbage whenever no read is issued.
  always @(posedge clk) begin
    if (bus.inst_sram_en) bus.inst_sram_rdata <= mem_word(bus.inst_sram_addr);
    else                  bus.inst_sram_rdata <= $urandom;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Program-order model: every delivered inst must be the next one in order and match memory.
  always @(negedge clk) begin
    if (reset) begin
      chk("m_rst_valid", {31'h0, bus.fs_to_ds_valid}, 32'h0);
      chk("m_rst_en", {31'h0, bus.inst_sram_en}, 32'h0);
      chk("m_rst_inst", bus.fs_inst, NOP_INST);
      exp_next = RESET_PC;
    end else begin
      chk("m_we", {28'h0, bus.inst_sram_we}, 32'h0);
      chk("m_wdata", bus.inst_sram_wdata, 32'h0);
      if (bus.br_taken) begin
        chk("m_br_squash", {31'h0, bus.fs_to_ds_valid}, 32'h0);
        exp_next = bus.br_target;
      end else if (bus.fs_to_ds_valid) begin
        chk("m_pc_order", bus.fs_pc, exp_next);
        chk("m_inst", bus.fs_inst, exp_inst(bus.fs_pc));
        if (bus.ds_allowin) exp_next = exp_next + 32'd4;
      end else begin
        chk("m_nop_idle", bus.fs_inst, NOP_INST);
      end
    end
  end

  initial begin
    logic [15:0] pat;
    checks = 0;
    errors = 0;
    exp_next = RESET_PC;
    reset = 1'b1;
    bus.ds_allowin = 1'b1;
    bus.br_taken = 1'b0;
    bus.br_target = 32'h0;
    bus.inst_sram_rdata = 32'h0;
    cyc(); cyc();
    @(negedge clk);
    chk("rst_valid", {31'h0, bus.fs_to_ds_valid}, 32'h0);
    chk("rst_en", {31'h0, bus.inst_sram_en}, 32'h0);
    chk("rst_inst", bus.fs_inst, NOP_INST);
    chk("rst_pc", bus.fs_pc, 32'h1bfffffc);

    cyc(); reset = 1'b0;
    @(negedge clk);
    chk("boot_en", {31'h0, bus.inst_sram_en}, 32'h1);
    chk("boot_addr", bus.inst_sram_addr, 32'h1c000000);
    chk("boot_valid", {31'h0, bus.fs_to_ds_valid}, 32'h0);
    cyc(); @(negedge clk);
    chk("seq0_valid", {31'h0, bus.fs_to_ds_valid}, 32'h1);
    chk("seq0_pc", bus.fs_pc, 32'h1c000000);
    chk("seq0_inst", bus.fs_inst, 32'h0000ffff);
    cyc(); @(negedge clk);
    chk("seq1_pc", bus.fs_pc, 32'h1c000004);

    // Redirect while ID is free: 0x1c000008 must be dropped.
    cyc(); bus.br_taken = 1'b1; bus.br_target = 32'h1c000100;
    @(negedge clk);
    chk("br_drop_valid", {31'h0, bus.fs_to_ds_valid}, 32'h0);
    chk("br_hold_pc", bus.fs_pc, 32'h1c000008);
    chk("br_addr", bus.inst_sram_addr, 32'h1c000100);
    chk("br_en", {31'h0, bus.inst_sram_en}, 32'h1);
    cyc(); bus.br_taken = 1'b0;
    @(negedge clk);
    chk("br_tgt_valid", {31'h0, bus.fs_to_ds_valid}, 32'h1);
    chk("br_tgt_pc", bus.fs_pc, 32'h1c000100);

    // Three-cycle stall with garbage on the SRAM bus.
    cyc(); bus.ds_allowin = 1'b0;
    @(negedge clk);
    chk("stall_pc", bus.fs_pc, 32'h1c000104);
    chk("stall_inst", bus.fs_inst, 32'h0104fefb);
    chk("stall_en", {31'h0, bus.inst_sram_en}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cyc(); @(negedge clk);
      chk("stall_hold_pc", bus.fs_pc, 32'h1c000104);
      chk("stall_hold_inst", bus.fs_inst, 32'h0104fefb);
      chk("stall_hold_en", {31'h0, bus.inst_sram_en}, 32'h0);
    end
    cyc(); bus.ds_allowin = 1'b1;
    @(negedge clk);
    chk("resume_en", {31'h0, bus.inst_sram_en}, 32'h1);
    chk("resume_addr", bus.inst_sram_addr, 32'h1c000108);
    cyc(); @(negedge clk);
    chk("resume_pc", bus.fs_pc, 32'h1c000108);

    // Redirect under stall, re-asserted once while still stalled.
    cyc(); bus.ds_allowin = 1'b0; bus.br_taken = 1'b1; bus.br_target = 32'h1c000200;
    @(negedge clk);
    chk("bst_valid", {31'h0, bus.fs_to_ds_valid}, 32'h0);
    chk("bst_en", {31'h0, bus.inst_sram_en}, 32'h0);
    cyc(); bus.br_taken = 1'b0;
    @(negedge clk);
    chk("bst_pend_valid", {31'h0, bus.fs_to_ds_valid}, 32'h0);
    cyc(); bus.br_taken = 1'b1;
    @(negedge clk);
    chk("bst_rep_valid", {31'h0, bus.fs_to_ds_valid}, 32'h0);
    cyc(); bus.br_taken = 1'b0; bus.ds_allowin = 1'b1;
    @(negedge clk);
    chk("bst_rel_en", {31'h0, bus.inst_sram_en}, 32'h1);
    chk("bst_rel_addr", bus.inst_sram_addr, 32'h1c000200);
    chk("bst_rel_valid", {31'h0, bus.fs_to_ds_valid}, 32'h0);
    cyc(); @(negedge clk);
    chk("bst_tgt_pc", bus.fs_pc, 32'h1c000200);
    chk("bst_tgt_inst", bus.fs_inst, 32'h0200fdff);

    // Async reset mid-stall with a redirect pending.
    cyc(); bus.ds_allowin = 1'b0; bus.br_taken = 1'b1; bus.br_target = 32'h1c000300;
    cyc(); bus.br_taken = 1'b0;
    #2; reset = 1'b1;
    #1;
    chk("arst_valid", {31'h0, bus.fs_to_ds_valid}, 32'h0);
    chk("arst_en", {31'h0, bus.inst_sram_en}, 32'h0);
    chk("arst_inst", bus.fs_inst, NOP_INST);
    chk("arst_pc", bus.fs_pc, 32'h1bfffffc);
    cyc(); cyc(); reset = 1'b0; bus.ds_allowin = 1'b1;
    @(negedge clk);
    chk("arel_addr", bus.inst_sram_addr, RESET_PC);
    chk("arel_en", {31'h0, bus.inst_sram_en}, 32'h1);
    cyc(); @(negedge clk);
    chk("arel_pc", bus.fs_pc, RESET_PC);

    // Mixed back-pressure pattern, checked by the model only.
    pat = 16'b1011_0010_1110_0110;
    for (int i = 0; i < 16; i++) begin
      cyc(); bus.ds_allowin = pat[i];
    end
    cyc(); bus.ds_allowin = 1'b1;

`ifdef IF_ADEF_CHECK_EN
    cyc(); bus.br_taken = 1'b1; bus.br_target = 32'h1c000102;
    @(negedge clk);
    chk("adef_en", {31'h0, bus.inst_sram_en}, 32'h0);
    cyc(); bus.br_taken = 1'b0;
    @(negedge clk);
    chk("adef_flag", {31'h0, bus.fs_adef}, 32'h1);
    chk("adef_pc", bus.fs_pc, 32'h1c000102);
    chk("adef_inst", bus.fs_inst, NOP_INST);
    chk("adef_valid", {31'h0, bus.fs_to_ds_valid}, 32'h1);
    cyc(); bus.br_taken = 1'b1; bus.br_target = 32'h1c000400;
    cyc(); bus.br_taken = 1'b0;
    @(negedge clk);
    chk("adef_clr", {31'h0, bus.fs_adef}, 32'h0);
    chk("adef_clr_pc", bus.fs_pc, 32'h1c000400);
`endif

    cyc(); cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
